// File: rtl/beep_note_decoder_if.sv
// rtl/beep_note_decoder_if.sv - event handshake bundle between the beep note decoder and its consumer
interface beep_note_decoder_if;
   logic        ev_valid;
   logic        ev_ready;
   logic [7:0]  ev_note;
   logic [31:0] ev_dur;

   modport master (output ev_valid, output ev_note, output ev_dur, input ev_ready);
   modport slave  (input ev_valid, input ev_note, input ev_dur, output ev_ready);
endinterface

// File: rtl/beep_note_decoder.sv
// rtl/beep_note_decoder.sv - measures a square-wave beep period, classifies it to a MIDI note
// and emits (note, duration_ms) events on every committed note change.
module beep_note_decoder #(
   parameter int CLK_FREQ       = 100_000_000,
   parameter int NOTE_LO        = 48,
   parameter int NOTE_HI        = 95,
   parameter int STABLE_PERIODS = 3,
   parameter int SILENCE_MS     = 20
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 beep_i,
   output logic [7:0]           cur_note_o,
   output logic                 overflow_o,
   beep_note_decoder_if.master  ev
);
   localparam int NUM_B = NOTE_HI - NOTE_LO + 2;
   localparam int IW    = $clog2(NUM_B);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NOTE_HI - NOTE_LO);
   localparam logic [7:0]    NOTE_LO_B = 8'(NOTE_LO);
   localparam logic [7:0]    STABLE_N  = 8'(STABLE_PERIODS);
   localparam logic [31:0]   TICK_LAST = 32'(CLK_FREQ / 1000 - 1);
   localparam longint        SIL_L     = longint'(SILENCE_MS) * longint'(CLK_FREQ) / 1000;
   localparam logic [31:0]   SIL_CYC   = 32'(SIL_L);

   // Upper period edge of note n's bin: geometric midpoint between P(n) and P(n-1).
   function automatic logic [31:0] bound_of(input int n);
      real p;
      p = real'(CLK_FREQ) / (440.0 * (2.0 ** (real'(2 * (n - 69) - 1) / 24.0)));
      return 32'($rtoi(p + 0.5));
   endfunction

   logic [31:0] bound [NUM_B];
   for (genvar g = 0; g < NUM_B; g++) begin : g_bound
      localparam logic [31:0] BV = bound_of(NOTE_LO + g);
      assign bound[g] = BV;
   end

   typedef enum logic [1:0] {IDLE, SEARCH, COMMIT} state_t;
   state_t state_q, state_d;

   logic          sync1_q, sync2_q, sync3_q;
   logic [31:0]   per_cnt_q, per_cnt_d, per_q, per_d;
   logic          per_valid_q, per_valid_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [7:0]    cls_q, cls_d, cand_q, cand_d, cnt_q, cnt_d, cur_note_q, cur_note_d;
   logic [31:0]   tick_cnt_q, tick_cnt_d, dur_q, dur_d;
   logic          ev_valid_q, ev_valid_d, overflow_q, overflow_d;
   logic [7:0]    ev_note_q, ev_note_d;
   logic [31:0]   ev_dur_q, ev_dur_d;
   logic          rise, tick, silent, change;
   logic [7:0]    new_note;

   assign rise   = sync2_q & ~sync3_q;
   assign tick   = (tick_cnt_q == TICK_LAST);
   assign silent = (per_cnt_q >= SIL_CYC);

   always_comb begin
      state_d     = state_q;
      per_cnt_d   = per_cnt_q;
      per_d       = per_q;
      per_valid_d = per_valid_q;
      idx_d       = idx_q;
      cls_d       = cls_q;
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      cur_note_d  = cur_note_q;
      tick_cnt_d  = tick ? 32'd0 : tick_cnt_q + 32'd1;
      dur_d       = dur_q;
      ev_valid_d  = ev_valid_q;
      ev_note_d   = ev_note_q;
      ev_dur_d    = ev_dur_q;
      overflow_d  = overflow_q;
      change      = 1'b0;
      new_note    = cur_note_q;

      if (rise)                    per_cnt_d = 32'd0;
      else if (per_cnt_q != '1)    per_cnt_d = per_cnt_q + 32'd1;
      if (tick && dur_q != '1)     dur_d = dur_q + 32'd1;

      case (state_q)
         IDLE: begin
            if (rise && per_valid_q) begin
               per_d   = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + 32'd1;
               idx_d   = '0;
               state_d = SEARCH;
            end
         end
         SEARCH: begin
            if (per_q > bound[idx_q]) begin
               cls_d   = 8'd0;
               state_d = COMMIT;
            end else if (per_q > bound[idx_q + IW'(1)]) begin
               cls_d   = NOTE_LO_B + 8'(idx_q);
               state_d = COMMIT;
            end else if (idx_q == IDX_LAST) begin
               cls_d   = 8'd0;
               state_d = COMMIT;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         COMMIT: begin
            state_d = IDLE;
            if (cls_q == cand_q) begin
               if (cnt_q != '1) cnt_d = cnt_q + 8'd1;
            end else begin
               cand_d = cls_q;
               cnt_d  = 8'd1;
            end
            if (cnt_d >= STABLE_N && cls_q != cur_note_q) begin
               change   = 1'b1;
               new_note = cls_q;
            end
         end
         default: state_d = IDLE;
      endcase

      // Silence overrides any classification and forgets the tone history.
      if (silent) begin
         per_valid_d = 1'b0;
         cand_d      = 8'd0;
         cnt_d       = 8'd0;
         change      = (cur_note_q != 8'd0);
         new_note    = 8'd0;
      end
      if (rise) per_valid_d = 1'b1;

      if (change) begin
         cur_note_d = new_note;
         dur_d      = 32'd0;
         if (!ev_valid_q || ev.ev_ready) begin
            ev_valid_d = 1'b1;
            ev_note_d  = cur_note_q;
            ev_dur_d   = dur_q;
         end else begin
            overflow_d = 1'b1;
         end
      end else if (ev.ev_ready) begin
         ev_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         sync3_q     <= 1'b0;
         per_cnt_q   <= '0;
         per_q       <= '0;
         per_valid_q <= 1'b0;
         idx_q       <= '0;
         cls_q       <= '0;
         cand_q      <= '0;
         cnt_q       <= '0;
         cur_note_q  <= '0;
         tick_cnt_q  <= '0;
         dur_q       <= '0;
         ev_valid_q  <= 1'b0;
         ev_note_q   <= '0;
         ev_dur_q    <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= beep_i;
         sync2_q     <= sync1_q;
         sync3_q     <= sync2_q;
         per_cnt_q   <= per_cnt_d;
         per_q       <= per_d;
         per_valid_q <= per_valid_d;
         idx_q       <= idx_d;
         cls_q       <= cls_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         cur_note_q  <= cur_note_d;
         tick_cnt_q  <= tick_cnt_d;
         dur_q       <= dur_d;
         ev_valid_q  <= ev_valid_d;
         ev_note_q   <= ev_note_d;
         ev_dur_q    <= ev_dur_d;
         overflow_q  <= overflow_d;
      end
   end

   assign cur_note_o  = cur_note_q;
   assign overflow_o  = overflow_q;
   assign ev.ev_valid = ev_valid_q;
   assign ev.ev_note  = ev_note_q;
   assign ev.ev_dur   = ev_dur_q;
endmodule

// File: tb/tb_beep_note_decoder.sv
// tb/tb_beep_note_decoder.sv - scoreboard bench for beep_note_decoder at a 100 kHz clock
module tb_beep_note_decoder;
   localparam int CLK_FREQ = 100_000;
   localparam int TICK     = CLK_FREQ / 1000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       beep;
   logic [7:0] cur_note;
   logic       overflow;

   beep_note_decoder_if ev_if ();

   beep_note_decoder #(.CLK_FREQ(CLK_FREQ)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .beep_i     (beep),
      .cur_note_o (cur_note),
      .overflow_o (overflow),
      .ev         (ev_if)
   );

   always #5 clk = ~clk;

   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;
   longint t_rst = 0;
   longint last_rise = 0;
   int     half = 0;
   logic   hold_lvl = 1'b0;
   int     rise_cnt = 0;
   int     phase = 0;

   typedef struct {
      logic [7:0] note;
      longint     lo;
      longint     hi;
   } ev_t;
   ev_t sb[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Tone generator: half-period in clocks, or a held level when half is 0.
   initial begin
      beep = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (half == 0) begin
            beep  = hold_lvl;
            phase = 0;
         end else if (phase >= half - 1) begin
            beep  = ~beep;
            phase = 0;
            if (beep) begin
               rise_cnt  = rise_cnt + 1;
               last_rise = cyc;
            end
         end else begin
            phase = phase + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && ev_if.ev_valid && ev_if.ev_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL spurious_event note=%0d dur=%0d expected none", ev_if.ev_note, ev_if.ev_dur);
         end else begin
            ev_t e;
            e = sb.pop_front();
            if (ev_if.ev_note !== e.note || longint'(ev_if.ev_dur) < e.lo || longint'(ev_if.ev_dur) > e.hi) begin
               errors++;
               $display("FAIL event note=%0d dur=%0d expected note=%0d dur in [%0d,%0d]",
                        ev_if.ev_note, ev_if.ev_dur, e.note, e.lo, e.hi);
            end
         end
      end
   end

   function automatic int exp_note(input int period);
      real n;
      int  r;
      n = 69.0 + 12.0 * $ln(real'(CLK_FREQ) / (440.0 * real'(period))) / $ln(2.0);
      r = int'($floor(n + 0.5));
      if (r < 48 || r > 95) r = 0;
      return r;
   endfunction

   task automatic wait_rises(input int n);
      int k = 0;
      while (rise_cnt < n && k < 60000) begin
         @(posedge clk);
         #2;
         k++;
      end
      if (rise_cnt < n) begin
         checks++;
         errors++;
         $display("FAIL wait_rises timeout got %0d need %0d", rise_cnt, n);
      end
   endtask

   task automatic wait_until(input longint t);
      while (cyc < t) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset;
      @(posedge clk);
      #1;
      rst = 1'b1;
      half = 0;
      hold_lvl = 1'b0;
      ev_if.ev_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      t_rst = cyc;
      rise_cnt = 0;
      sb.delete();
   endtask

   task automatic push_first;
      longint l;
      l = last_rise - t_rst;
      sb.push_back('{note: 8'd0, lo: l / TICK - 1, hi: (l + 60) / TICK + 1});
   endtask

   task automatic release_when_low;
      int k = 0;
      while (beep !== 1'b0 && k < 1000) begin
         @(posedge clk);
         #2;
         k++;
      end
      rst = 1'b0;
      t_rst = cyc;
      rise_cnt = 0;
      ev_if.ev_ready = 1'b1;
      sb.delete();
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (cur_note !== 8'd0 || overflow !== 1'b0 || ev_if.ev_valid !== 1'b0 ||
          ev_if.ev_note !== 8'd0 || ev_if.ev_dur !== 32'd0) begin
         errors++;
         $display("FAIL reset_state note=%0d ovf=%0b v=%0b en=%0d ed=%0d expected all 0",
                  cur_note, overflow, ev_if.ev_valid, ev_if.ev_note, ev_if.ev_dur);
      end
      do_reset();
      repeat (20) @(posedge clk);
      #2;
      checks++;
      if (cur_note !== 8'd0 || ev_if.ev_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset note=%0d v=%0b expected 0 0", cur_note, ev_if.ev_valid);
      end
   endtask

   task automatic test_first_note;
      do_reset();
      half = 114;
      wait_rises(4);
      push_first();
      checks++;
      if (cur_note !== 8'd0) begin
         errors++;
         $display("FAIL first_note_early got %0d expected 0", cur_note);
      end
      wait_until(last_rise + 55);
      checks++;
      if (cur_note !== 8'(exp_note(228))) begin
         errors++;
         $display("FAIL first_note got %0d expected %0d", cur_note, exp_note(228));
      end
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL first_note_event pending=%0d ovf=%0b expected 0 0", sb.size(), overflow);
      end
   endtask

   task automatic test_note_change;
      longint t_first, ts;
      int b;
      do_reset();
      half = 76;
      wait_rises(1);
      t_first = last_rise;
      wait_rises(4);
      push_first();
      wait_until(t_first + 20000);
      checks++;
      if (cur_note !== 8'(exp_note(152))) begin
         errors++;
         $display("FAIL held_note got %0d expected %0d", cur_note, exp_note(152));
      end
      ts = cyc;
      sb.push_back('{note: 8'(exp_note(152)), lo: (ts - t_first - 96) / TICK - 1,
                     hi: (ts - t_first + 384) / TICK + 1});
      half = 101;
      b = rise_cnt;
      wait_rises(b + 5);
      wait_until(last_rise + 40);
      checks++;
      if (cur_note !== 8'(exp_note(202)) || sb.size() != 0) begin
         errors++;
         $display("FAIL changed_note got %0d pending=%0d expected %0d pending=0",
                  cur_note, sb.size(), exp_note(202));
      end
   endtask

   task automatic test_silence;
      longint t4, tl;
      do_reset();
      half = 114;
      wait_rises(4);
      push_first();
      t4 = last_rise;
      wait_rises(6);
      half = 0;
      hold_lvl = 1'b1;
      tl = last_rise;
      sb.push_back('{note: 8'(exp_note(228)), lo: (tl + 2000 - t4 - 60) / TICK - 1,
                     hi: (tl + 2004 - t4) / TICK + 1});
      wait_until(tl + 1990);
      checks++;
      if (cur_note !== 8'(exp_note(228))) begin
         errors++;
         $display("FAIL pre_silence got %0d expected %0d", cur_note, exp_note(228));
      end
      wait_until(tl + 2015);
      checks++;
      if (cur_note !== 8'd0 || sb.size() != 0) begin
         errors++;
         $display("FAIL silence_rest got %0d pending=%0d expected 0 pending=0", cur_note, sb.size());
      end
   endtask

   task automatic test_overflow;
      int b;
      do_reset();
      ev_if.ev_ready = 1'b0;
      half = 114;
      wait_rises(4);
      push_first();
      wait_until(last_rise + 60);
      checks++;
      if (ev_if.ev_valid !== 1'b1 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_first v=%0b ovf=%0b expected 1 0", ev_if.ev_valid, overflow);
      end
      half = 96;
      b = rise_cnt;
      wait_rises(b + 6);
      wait_until(last_rise + 60);
      half = 76;
      b = rise_cnt;
      wait_rises(b + 6);
      wait_until(last_rise + 60);
      checks++;
      if (cur_note !== 8'(exp_note(152)) || overflow !== 1'b1 ||
          ev_if.ev_valid !== 1'b1 || ev_if.ev_note !== 8'd0) begin
         errors++;
         $display("FAIL ovf_held note=%0d ovf=%0b v=%0b en=%0d expected %0d 1 1 0",
                  cur_note, overflow, ev_if.ev_valid, ev_if.ev_note, exp_note(152));
      end
      ev_if.ev_ready = 1'b1;
      @(posedge clk);
      #2;
      checks++;
      if (ev_if.ev_valid !== 1'b0 || sb.size() != 0 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_accept v=%0b pending=%0d ovf=%0b expected 0 0 1",
                  ev_if.ev_valid, sb.size(), overflow);
      end
   endtask

   task automatic test_out_of_range;
      int b;
      do_reset();
      half = 2500;
      wait_rises(3);
      checks++;
      if (cur_note !== 8'd0) begin
         errors++;
         $display("FAIL low_tone got %0d expected 0", cur_note);
      end
      half = 10;
      b = rise_cnt;
      wait_rises(b + 30);
      repeat (60) @(posedge clk);
      #2;
      checks++;
      if (cur_note !== 8'd0 || ev_if.ev_valid !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL high_tone note=%0d v=%0b ovf=%0b expected 0 0 0",
                  cur_note, ev_if.ev_valid, overflow);
      end
   endtask

   task automatic test_reset_mid;
      do_reset();
      ev_if.ev_ready = 1'b0;
      half = 96;
      wait_rises(5);
      wait_until(last_rise + 100);
      checks++;
      if (cur_note !== 8'(exp_note(192)) || ev_if.ev_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_note note=%0d v=%0b expected %0d 1", cur_note, ev_if.ev_valid, exp_note(192));
      end
      rst = 1'b1;
      #1;
      checks++;
      if (cur_note !== 8'd0 || ev_if.ev_valid !== 1'b0 || ev_if.ev_note !== 8'd0 ||
          ev_if.ev_dur !== 32'd0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL async_reset note=%0d v=%0b en=%0d ed=%0d ovf=%0b expected all 0",
                  cur_note, ev_if.ev_valid, ev_if.ev_note, ev_if.ev_dur, overflow);
      end
      @(posedge clk);
      #2;
      release_when_low();
      wait_rises(3);
      wait_until(last_rise + 60);
      checks++;
      if (cur_note !== 8'd0) begin
         errors++;
         $display("FAIL relearn_early got %0d expected 0", cur_note);
      end
      wait_rises(4);
      push_first();
      wait_until(last_rise + 60);
      checks++;
      if (cur_note !== 8'(exp_note(192)) || sb.size() != 0) begin
         errors++;
         $display("FAIL relearn got %0d pending=%0d expected %0d 0", cur_note, sb.size(), exp_note(192));
      end
      wait_rises(5);
      wait_until(last_rise + 12);
      rst = 1'b1;
      #1;
      checks++;
      if (cur_note !== 8'd0 || ev_if.ev_valid !== 1'b0) begin
         errors++;
         $display("FAIL search_reset note=%0d v=%0b expected 0 0", cur_note, ev_if.ev_valid);
      end
      @(posedge clk);
      #2;
      release_when_low();
      wait_rises(4);
      push_first();
      wait_until(last_rise + 60);
      checks++;
      if (cur_note !== 8'(exp_note(192)) || sb.size() != 0) begin
         errors++;
         $display("FAIL relearn_search got %0d pending=%0d expected %0d 0", cur_note, sb.size(), exp_note(192));
      end
      half = 0;
   endtask

   initial begin
      ev_if.ev_ready = 1'b1;
      test_reset();
      test_first_note();
      test_note_change();
      test_silence();
      test_overflow();
      test_out_of_range();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
